// File: rtl/cosim_loopback_buffer_if.sv
// Token stream between a cosim endpoint and the loopback buffer.
// The master drives DataOut* and accepts DataIn*; the slave is the buffer.
interface cosim_loopback_buffer_if #(
    parameter int unsigned TYPE_SIZE_BITS = 23
);
    logic                      DataOutValid;
    logic                      DataOutReady;
    logic [TYPE_SIZE_BITS-1:0] DataOut;
    logic                      DataInValid;
    logic                      DataInReady;
    logic [TYPE_SIZE_BITS-1:0] DataIn;

    modport master (
        output DataOutValid, DataOut, DataInReady,
        input  DataOutReady, DataInValid, DataIn
    );

    modport slave (
        input  DataOutValid, DataOut, DataInReady,
        output DataOutReady, DataInValid, DataIn
    );
endinterface

// File: rtl/cosim_loopback_buffer.sv
// Elastic FIFO echoing an endpoint's outbound token stream back to its inbound stream,
// with running counts of tokens received and sent.
module cosim_loopback_buffer #(
    parameter int unsigned TYPE_SIZE_BITS = 23,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned CNT_BITS       = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    cosim_loopback_buffer_if.slave     bus,
    input  logic                       Flush,
    output logic [$clog2(DEPTH):0]     Occupancy,
    output logic [CNT_BITS-1:0]        RecvCount,
    output logic [CNT_BITS-1:0]        SentCount
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [TYPE_SIZE_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic                      push;
    logic                      pop;

    // Full/empty come only from Occupancy; readiness ignores a same-cycle pop.
    always_comb begin
        bus.DataOutReady = (Occupancy != OCC_W'(DEPTH));
        bus.DataInValid  = (Occupancy != '0);
        bus.DataIn       = bus.DataInValid ? mem[rd_ptr] : '0;
        push             = bus.DataOutValid && bus.DataOutReady && !Flush;
        pop              = bus.DataInValid && bus.DataInReady && !Flush;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.DataOut;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Occupancy <= '0;
            RecvCount <= '0;
            SentCount <= '0;
        end else if (Flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                RecvCount <= RecvCount + CNT_BITS'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                SentCount <= SentCount + CNT_BITS'(1);
            end
            case ({push, pop})
                2'b10:   Occupancy <= Occupancy + OCC_W'(1);
                2'b01:   Occupancy <= Occupancy - OCC_W'(1);
                default: Occupancy <= Occupancy;
            endcase
        end
    end
endmodule
